// File: rtl/adv_timer_input_filter_if.sv
// adv_timer_input_filter_if: pad inputs, per-channel filter config and filtered outputs of the timer input filter.
interface adv_timer_input_filter_if #(
    parameter int N_SIG = 4,
    parameter int FLT_W = 8,
    parameter int CNT_W = 16
);
    logic [N_SIG-1:0]       ext_sig_i;
    logic [N_SIG-1:0]       cfg_en_i;
    logic [N_SIG*FLT_W-1:0] cfg_flt_len_i;
    logic [N_SIG-1:0]       cfg_cnt_clr_i;
    logic [N_SIG-1:0]       sig_o;
    logic [N_SIG-1:0]       rise_o;
    logic [N_SIG-1:0]       fall_o;
    logic [N_SIG*CNT_W-1:0] edge_cnt_o;
    modport master (
        output ext_sig_i, cfg_en_i, cfg_flt_len_i, cfg_cnt_clr_i,
        input  sig_o, rise_o, fall_o, edge_cnt_o
    );
    modport slave (
        input  ext_sig_i, cfg_en_i, cfg_flt_len_i, cfg_cnt_clr_i,
        output sig_o, rise_o, fall_o, edge_cnt_o
    );
endinterface

// File: rtl/adv_timer_input_filter.sv
// adv_timer_input_filter: per-channel synchronizer, stability glitch filter, edge pulses and saturating edge counter.
module adv_timer_input_filter #(
    parameter int N_SIG = 4,
    parameter int FLT_W = 8,
    parameter int CNT_W = 16
) (
    input logic                    HCLK,
    input logic                    HRESET,
    adv_timer_input_filter_if.slave bus
);
    for (genvar n = 0; n < N_SIG; n++) begin : g_ch
        logic             sync1, sync2, flt, rise, fall, diff, acc;
        logic [FLT_W-1:0] stab, len;
        logic [CNT_W-1:0] cnt;
        assign len  = bus.cfg_flt_len_i[n*FLT_W +: FLT_W];
        assign diff = bus.cfg_en_i[n] && (sync2 != flt);
        // >= rather than == so a length lowered mid-count accepts at once
        assign acc  = diff && (stab >= len);
        always_ff @(posedge HCLK or posedge HRESET) begin
            if (HRESET) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                stab  <= '0;
                flt   <= 1'b0;
                rise  <= 1'b0;
                fall  <= 1'b0;
                cnt   <= '0;
            end else begin
                sync1 <= bus.ext_sig_i[n];
                sync2 <= sync1;
                stab  <= (diff && !acc) ? stab + 1'b1 : '0;
                flt   <= acc ? sync2 : flt;
                rise  <= acc && sync2;
                fall  <= acc && !sync2;
                cnt   <= bus.cfg_cnt_clr_i[n] ? '0 : (acc && !(&cnt)) ? cnt + 1'b1 : cnt;
            end
        end
        assign bus.sig_o[n]                    = flt;
        assign bus.rise_o[n]                   = rise;
        assign bus.fall_o[n]                   = fall;
        assign bus.edge_cnt_o[n*CNT_W +: CNT_W] = cnt;
    end
endmodule

// File: tb/tb_adv_timer_input_filter.sv
// tb_adv_timer_input_filter: directed and random stimulus against a run-length reference model.
module tb_adv_timer_input_filter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adv_timer_input_filter_if #(.N_SIG(4), .FLT_W(8), .CNT_W(16)) bus ();
    adv_timer_input_filter_if #(.N_SIG(1), .FLT_W(8), .CNT_W(4))  sbus ();

    adv_timer_input_filter #(.N_SIG(4), .FLT_W(8), .CNT_W(16)) dut (
        .HCLK(clk), .HRESET(rst), .bus(bus.slave));
    // narrow-counter instance so saturation is reachable quickly
    adv_timer_input_filter #(.N_SIG(1), .FLT_W(8), .CNT_W(4)) sdut (
        .HCLK(clk), .HRESET(rst), .bus(sbus.slave));

    bit sig[5], en[5], clr[5];
    int len[5];
    bit m_s1[5], m_s2[5], m_flt[5], m_rise[5], m_fall[5];
    int m_streak[5], m_cnt[5];
    int total = 0;
    int bad = 0;

    task automatic drive();
        for (int c = 0; c < 4; c++) begin
            bus.ext_sig_i[c]            = sig[c];
            bus.cfg_en_i[c]             = en[c];
            bus.cfg_cnt_clr_i[c]        = clr[c];
            bus.cfg_flt_len_i[c*8 +: 8] = len[c][7:0];
        end
        sbus.ext_sig_i[0]     = sig[4];
        sbus.cfg_en_i[0]      = en[4];
        sbus.cfg_cnt_clr_i[0] = clr[4];
        sbus.cfg_flt_len_i    = len[4][7:0];
    endtask

    task automatic model_zero();
        for (int c = 0; c < 5; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_flt[c] = 0; m_rise[c] = 0; m_fall[c] = 0;
            m_streak[c] = 0; m_cnt[c] = 0;
        end
    endtask

    // streak = consecutive enabled cycles the synchronized level disagreed with the accepted level
    task automatic model_edge();
        if (rst) begin
            model_zero();
            return;
        end
        for (int c = 0; c < 5; c++) begin
            bit acc;
            int top;
            acc = 0;
            top = (c < 4) ? 65535 : 15;
            if (en[c] && m_s2[c] != m_flt[c]) begin
                if (m_streak[c] >= len[c]) acc = 1;
                else m_streak[c]++;
            end else m_streak[c] = 0;
            if (acc) begin
                m_streak[c] = 0;
                m_flt[c] = m_s2[c];
            end
            m_rise[c] = acc && m_s2[c];
            m_fall[c] = acc && !m_s2[c];
            m_cnt[c] = clr[c] ? 0 : (acc && m_cnt[c] < top) ? m_cnt[c] + 1 : m_cnt[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = sig[c];
        end
    endtask

    task automatic chk(string tag, int c, logic [31:0] act, logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s ch%0d got=%0h exp=%0h", tag, c, act, exp);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 4; c++) begin
            chk("sig", c, 32'(bus.sig_o[c]), 32'(m_flt[c]));
            chk("rise", c, 32'(bus.rise_o[c]), 32'(m_rise[c]));
            chk("fall", c, 32'(bus.fall_o[c]), 32'(m_fall[c]));
            chk("cnt", c, 32'(bus.edge_cnt_o[c*16 +: 16]), 32'(m_cnt[c]));
        end
        chk("sig", 4, 32'(sbus.sig_o[0]), 32'(m_flt[4]));
        chk("rise", 4, 32'(sbus.rise_o[0]), 32'(m_rise[4]));
        chk("fall", 4, 32'(sbus.fall_o[0]), 32'(m_fall[4]));
        chk("cnt", 4, 32'(sbus.edge_cnt_o), 32'(m_cnt[4]));
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(int k);
        repeat (k) step();
    endtask

    initial begin
        for (int c = 0; c < 5; c++) begin
            en[c] = 1; len[c] = 2;
        end
        len[0] = 0;
        drive();
        steps(3);
        rst = 1'b0;
        steps(3);
        // L=0 rise: visible at the third edge counting the first sampling edge
        sig[0] = 1;
        steps(3);
        chk("r032_sig", 0, 32'(bus.sig_o[0]), 32'd1);
        chk("r032_rise", 0, 32'(bus.rise_o[0]), 32'd1);
        chk("r032_cnt", 0, 32'(bus.edge_cnt_o[15:0]), 32'd1);
        step();
        chk("r032_rise_once", 0, 32'(bus.rise_o[0]), 32'd0);
        // L=4: four-cycle glitch rejected, five-cycle level accepted at edge 7
        len[1] = 4;
        sig[1] = 1;
        steps(4);
        sig[1] = 0;
        steps(10);
        chk("r033_glitch", 1, 32'(bus.sig_o[1]), 32'd0);
        chk("r033_cnt", 1, 32'(bus.edge_cnt_o[31:16]), 32'd0);
        sig[1] = 1;
        steps(6);
        chk("r033_early", 1, 32'(bus.sig_o[1]), 32'd0);
        step();
        chk("r033_accept", 1, 32'(bus.sig_o[1]), 32'd1);
        // disabled channel ignores toggling, then restarts from a settled input
        len[2] = 2;
        en[2] = 0;
        sig[2] = 1; steps(2);
        sig[2] = 0; steps(2);
        sig[2] = 1; steps(4);
        chk("r034_hold", 2, 32'(bus.sig_o[2]), 32'd0);
        chk("r034_cnt", 2, 32'(bus.edge_cnt_o[47:32]), 32'd0);
        en[2] = 1;
        steps(2);
        chk("r034_early", 2, 32'(bus.sig_o[2]), 32'd0);
        step();
        chk("r034_accept", 2, 32'(bus.sig_o[2]), 32'd1);
        // independent channels with distinct lengths and simultaneous edges
        len[0] = 0; len[1] = 1; len[2] = 3; len[3] = 7;
        for (int c = 0; c < 4; c++) sig[c] = 0;
        steps(15);
        for (int c = 0; c < 4; c++) sig[c] = 1;
        for (int k = 1; k <= 11; k++) begin
            step();
            for (int c = 0; c < 4; c++)
                chk("r037_sig", c, 32'(bus.sig_o[c]), 32'(k >= 3 + len[c]));
        end
        // length lowered below the running count mid-transition
        sig[3] = 0;
        steps(5);
        len[3] = 2;
        steps(3);
        // reset in the middle of a count discards it
        len[0] = 8;
        sig[0] = 0;
        steps(15);
        sig[0] = 1;
        steps(7);
        #2;
        rst = 1'b1;
        #1;
        model_zero();
        check_all();
        steps(2);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("r036_sig", 0, 32'(bus.sig_o[0]), 32'(k >= 11));
        end
        // random traffic on every channel
        repeat (400) begin
            for (int c = 0; c < 5; c++) begin
                if ($urandom_range(0, 3) == 0) sig[c] = !sig[c];
                en[c] = $urandom_range(0, 15) != 0;
                clr[c] = $urandom_range(0, 31) == 0;
                if ($urandom_range(0, 15) == 0) len[c] = $urandom_range(0, 3);
            end
            step();
        end
        for (int c = 0; c < 5; c++) clr[c] = 0;
        // saturation and clear-over-increment on the narrow counter
        en[4] = 1;
        len[4] = 0;
        steps(6);
        clr[4] = 1;
        step();
        clr[4] = 0;
        repeat (20) begin
            sig[4] = !sig[4];
            steps(4);
        end
        chk("r035_sat", 4, 32'(sbus.edge_cnt_o), 32'd15);
        sig[4] = !sig[4];
        steps(2);
        clr[4] = 1;
        step();
        clr[4] = 0;
        chk("r035_clr", 4, 32'(sbus.edge_cnt_o), 32'd0);
        chk("r035_edge", 4, 32'(sbus.rise_o[0] | sbus.fall_o[0]), 32'd1);
        steps(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
